serial_subtractor: RTL and testbench

- Bit-serial subtractor: computes diff = a - b - bin over WIDTH clock cycles, LSB first, one full-subtractor evaluation per cycle.
- Counterpart to the combinational full adder in the arithmetic library; reuses the single-bit cell idea but subtracts, with a borrow flop carrying state between cycles.
- Used where area matters more than latency; start/busy/done handshake to a controlling FSM.

---
 rtl/arith_pkg.sv | 13 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 150 +++++++++++++++
 tb/tb_serial_subtractor.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding for the
// bit-serial units and the default operand width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, with borrow-out.
// Purely combinational; sibling of the library full adder.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow-out of one bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first.
// One full_subtractor evaluation per cycle; the borrow is carried between
// cycles in a flop. start/busy/done handshake to a controlling FSM.
// Optional macro SERSUB_OVF_EN adds a signed-overflow output 'ovf'.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             bw_reg;
    logic             bout_reg;

    logic load;
    logic last;
    logic d_bit;
    logic bo_bit;

`ifdef SERSUB_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;
`endif

    // The one bit cell, fed from the operand LSBs and the running borrow.
    full_subtractor u_fs (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .bin  (bw_reg),
        .d    (d_bit),
        .bout (bo_bit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and Moore outputs; start is only looked at in IDLE.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        last       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    last       = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: capture on accepted start, shift one bit per RUN cycle.
    // diff is deliberately not cleared at start; it is overwritten bit by bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
            diff_reg <= '0;
            cnt_reg  <= '0;
            bw_reg   <= 1'b0;
            bout_reg <= 1'b0;
        end else if (load) begin
            a_sh_reg <= a;
            b_sh_reg <= b;
            bw_reg   <= bin;
            cnt_reg  <= '0;
        end else if (state_reg == ST_RUN) begin
            a_sh_reg <= a_sh_reg >> 1;
            b_sh_reg <= b_sh_reg >> 1;
            diff_reg <= {d_bit, diff_reg[WIDTH-1:1]};
            bw_reg   <= bo_bit;
            if (last) begin
                bout_reg <= bo_bit;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef SERSUB_OVF_EN
    // Signed overflow from the captured operand MSBs and the final diff MSB,
    // which is the bit produced on the last RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (load) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
        end else if (last) begin
            ovf_reg <= (a_msb_reg != b_msb_reg) && (d_bit != a_msb_reg);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign diff = diff_reg;
    assign bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Build with +define+SERSUB_OVF_EN to also exercise the overflow output.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             bin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERSUB_OVF_EN
    logic             ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERSUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Pulse start for one edge (edge 0), then scramble the operand inputs to
    // show they have no effect after capture. Returns the number of edges
    // after edge 0 at which done was first seen high (-1 on timeout).
    // Returns positioned in the done cycle.
    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic biv, output int lat);
        @(negedge clk);
        a = av; b = bv; bin = biv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv; bin = ~biv;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, diff, bout} !== '0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        $display("reset: busy=%b done=%b diff=%h bout=%b", busy, done, diff, bout);
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'h05, 8'h03, 1'b0, lat);
        checks++;
        if (lat !== WIDTH) begin
            errors++;
            $display("FAIL basic_latency: done after %0d edges, required %0d", lat, WIDTH);
        end
        checks++;
        if (diff !== 8'h02 || bout !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_result: diff=%h bout=%b busy=%b, required 02 0 1", diff, bout, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        checks++;
        if (diff !== 8'h02 || bout !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: diff=%h bout=%b, required 02 0", diff, bout);
        end
        $display("05-03-0: lat=%0d diff=%h bout=%b", lat, diff, bout);
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] va [3]   = '{8'h03, 8'h00, 8'hFF};
        logic [WIDTH-1:0] vb [3]   = '{8'h05, 8'h00, 8'h00};
        logic             vbi [3]  = '{1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] ed [3]   = '{8'hFE, 8'hFF, 8'hFF};
        logic             eb [3]   = '{1'b1, 1'b1, 1'b0};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vbi[i], lat);
            checks++;
            if (lat !== WIDTH || diff !== ed[i] || bout !== eb[i]) begin
                errors++;
                $display("FAIL vector%0d: lat=%0d diff=%h bout=%b, required %0d %h %b",
                         i, lat, diff, bout, WIDTH, ed[i], eb[i]);
            end
            $display("%h-%h-%b: lat=%0d diff=%h bout=%b", va[i], vb[i], vbi[i], lat, diff, bout);
        end
    endtask

    task automatic test_start_ignored();
        int pulses = 0;
        logic [WIDTH-1:0] got = '0;
        logic got_b = 1'b0;
        @(negedge clk);
        a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);                 // edge 0 done
        start = 1'b0;
        @(negedge clk);                 // edge 1
        @(negedge clk);                 // edge 2
        a = 8'h00; b = 8'hFF; bin = 1'b1; start = 1'b1;
        @(negedge clk);                 // edge 3, start ignored
        start = 1'b0;
        for (int k = 4; k <= 16; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                got = diff;
                got_b = bout;
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL ignore_pulses: %0d done pulses, required 1", pulses);
        end
        checks++;
        if (got !== 8'h0F || got_b !== 1'b0) begin
            errors++;
            $display("FAIL ignore_result: diff=%h bout=%b, required 0F 0", got, got_b);
        end
        $display("10-01 with restart: pulses=%0d diff=%h bout=%b", pulses, got, got_b);
    endtask

    task automatic test_reset_mid_run();
        int pulses = 0;
        int lat;
        @(negedge clk);
        a = 8'hFF; b = 8'h00; bin = 1'b0; start = 1'b1;
        @(negedge clk);                 // edge 0
        start = 1'b0;
        @(negedge clk);                 // edge 1
        @(negedge clk);                 // edge 2
        @(negedge clk);                 // edge 3
        @(posedge clk);                 // edge 4
        #1;
        checks++;
        if (diff !== 8'hF0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_partial: diff=%h busy=%b, required F0 1", diff, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, diff, bout} !== '0) begin
            errors++;
            $display("FAIL midrun_async: busy=%b done=%b diff=%h bout=%b, required all 0", busy, done, diff, bout);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL midrun_no_done: %0d done pulses, required 0", pulses);
        end
        run_op(8'h05, 8'h03, 1'b0, lat);
        checks++;
        if (lat !== WIDTH || diff !== 8'h02 || bout !== 1'b0) begin
            errors++;
            $display("FAIL midrun_recover: lat=%0d diff=%h bout=%b, required %0d 02 0", lat, diff, bout, WIDTH);
        end
        $display("reset mid-run: pulses=%0d, recovery diff=%h bout=%b", pulses, diff, bout);
    endtask

`ifdef SERSUB_OVF_EN
    task automatic test_ovf();
        int lat;
        run_op(8'h80, 8'h01, 1'b0, lat);
        checks++;
        if (lat !== WIDTH || diff !== 8'h7F || ovf !== 1'b1 || bout !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: diff=%h ovf=%b bout=%b, required 7F 1 0", diff, ovf, bout);
        end
        $display("80-01: diff=%h ovf=%b bout=%b", diff, ovf, bout);
        run_op(8'h05, 8'h03, 1'b0, lat);
        checks++;
        if (lat !== WIDTH || diff !== 8'h02 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: diff=%h ovf=%b, required 02 0", diff, ovf);
        end
        $display("05-03: diff=%h ovf=%b", diff, ovf);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_start_ignored();
        test_reset_mid_run();
`ifdef SERSUB_OVF_EN
        test_ovf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
